stateful_tbl_arb: RTL and testbench
===================================

STATEFUL_TBL_ARB -- requirements
Module: stateful_tbl_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4, sets the number of consecutive datapath grants allowed while a control-plane request waits.
REQ-002 Parameter HOLD_TIMEOUT, default 64, sets the maximum HOLD cycles before the lock is dropped.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 dp_req_vld / dp_req_rdy  input / output  1 / 1  datapath lookup handshake.
REQ-006 dp_req_idx  input  4  table entry for the datapath lookup.
REQ-007 dp_rsp_vld, dp_rsp_state, dp_rsp_action  output  1, 8, 16  lookup result: entry bits [7:0] and [23:8].
REQ-008 dp_upd_vld, dp_upd_wr, dp_upd_state  input  1, 1, 8  datapath state commit (wr=1) or release without write (wr=0).
REQ-009 cp_req_vld / cp_req_rdy  input / output  1 / 1  control-plane access handshake.
REQ-010 cp_req_wr, cp_req_idx, cp_req_wdata  input  1, 4, 24  write flag, entry index, full-entry write data.
REQ-011 cp_rsp_vld, cp_rsp_rdata  output  1, 24  control-plane read response.
REQ-012 timeout_err  output  1  one-cycle pulse when a HOLD lock expires.

Function
REQ-013 The block SHALL own a 16 x 24-bit register table, single access per cycle.
REQ-014 FSM states IDLE, HOLD; IDLE -> HOLD on datapath grant; HOLD -> IDLE on dp_upd_vld or on timeout.
REQ-015 dp_req_rdy SHALL be 1 only in IDLE and only when the CP is not being granted that cycle.
REQ-016 On dp grant, the block SHALL latch dp_req_idx as lock_idx and, next cycle, assert dp_rsp_vld for exactly one cycle with that entry's contents.
REQ-017 In HOLD, dp_upd_vld with dp_upd_wr=1 SHALL write dp_upd_state into entry lock_idx bits [7:0], leaving [23:8] unchanged; with dp_upd_wr=0 it SHALL not write.
REQ-018 dp_upd_vld outside HOLD, or in the cycle dp_rsp_vld is high, SHALL be ignored.
REQ-019 CP priority in IDLE: the CP is granted when dp_req_vld=0, or when starve_cnt equals STARVE_MAX.
REQ-020 starve_cnt SHALL increment on each datapath grant while cp_req_vld=1, saturate at STARVE_MAX, and clear on any CP grant.
REQ-021 In HOLD, the CP SHALL be granted when dp_upd_vld=0 and (cp_req_wr=0 or cp_req_idx != lock_idx); a CP write to lock_idx SHALL stall.
REQ-022 A CP write SHALL replace all 24 bits of the entry on the grant cycle; a CP read SHALL assert cp_rsp_vld with cp_rsp_rdata one cycle after grant.
REQ-023 A CP read in the same cycle as a table write sees the pre-write value.
REQ-024 hold_cnt SHALL count HOLD cycles; on reaching HOLD_TIMEOUT, the FSM SHALL return to IDLE, pulse timeout_err, and discard any later dp_upd.
REQ-025 Both *_rsp_vld outputs SHALL be single-cycle pulses; responses have no backpressure.

Reset
REQ-026 While reset=0, all outputs are 0 (dp_req_rdy and cp_req_rdy included), all table entries are 0, the FSM is IDLE, and starve_cnt and hold_cnt are 0.
REQ-027 Reset during HOLD SHALL drop the lock and any pending response without emitting it; the first grant is possible on the first clock edge after release.

Configuration
REQ-028 With STATE_TBL_STATS_EN defined, the block SHALL add the 16-bit saturating outputs dp_grant_cnt, cp_grant_cnt and timeout_cnt, cleared by reset.
REQ-029 Without STATE_TBL_STATS_EN, those ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-030 CP write idx 3 = 0x00AB12, then DP lookup idx 3 -> dp_rsp_vld next cycle, state=0x12, action=0x00AB.
REQ-031 DP lookup idx 3, then dp_upd wr=1 state=0x55 -> CP read idx 3 returns 0x00AB55; FSM back in IDLE.
REQ-032 dp_req_vld and cp_req_vld held high continuously -> the CP is granted after every 4 DP grants.
REQ-033 In HOLD on idx 5, CP write idx 5 stalls and CP write idx 6 is granted; after dp_upd, the idx 5 write completes.
REQ-034 DP lookup with no dp_upd -> timeout_err pulses after 64 HOLD cycles; a late dp_upd wr=1 leaves the entry unchanged.
REQ-035 Assert reset mid-HOLD -> outputs go to 0 immediately, the table clears, and a DP lookup after release returns 0.

Source files
------------

// File: rtl/stateful_tbl_arb_if.sv
// stateful_tbl_arb_if
//   Bundles the datapath lookup/update, control-plane access and error
//   signals of the stateful table arbiter.
//   master : the requester side (datapath + control plane agents)
//   slave  : the table arbiter itself
// Signals
//   dp_req_vld/rdy, dp_req_idx          datapath lookup handshake and entry
//   dp_rsp_vld, dp_rsp_state/action     lookup result, entry [7:0] / [23:8]
//   dp_upd_vld, dp_upd_wr, dp_upd_state state commit (wr=1) or release (wr=0)
//   cp_req_vld/rdy, cp_req_wr/idx/wdata control-plane access
//   cp_rsp_vld, cp_rsp_rdata            control-plane read data
//   timeout_err                         one-cycle pulse on lock expiry
interface stateful_tbl_arb_if;
  logic        dp_req_vld;
  logic        dp_req_rdy;
  logic [3:0]  dp_req_idx;
  logic        dp_rsp_vld;
  logic [7:0]  dp_rsp_state;
  logic [15:0] dp_rsp_action;
  logic        dp_upd_vld;
  logic        dp_upd_wr;
  logic [7:0]  dp_upd_state;
  logic        cp_req_vld;
  logic        cp_req_rdy;
  logic        cp_req_wr;
  logic [3:0]  cp_req_idx;
  logic [23:0] cp_req_wdata;
  logic        cp_rsp_vld;
  logic [23:0] cp_rsp_rdata;
  logic        timeout_err;

  modport master (
    output dp_req_vld, dp_req_idx, dp_upd_vld, dp_upd_wr, dp_upd_state,
           cp_req_vld, cp_req_wr, cp_req_idx, cp_req_wdata,
    input  dp_req_rdy, dp_rsp_vld, dp_rsp_state, dp_rsp_action,
           cp_req_rdy, cp_rsp_vld, cp_rsp_rdata, timeout_err
  );

  modport slave (
    input  dp_req_vld, dp_req_idx, dp_upd_vld, dp_upd_wr, dp_upd_state,
           cp_req_vld, cp_req_wr, cp_req_idx, cp_req_wdata,
    output dp_req_rdy, dp_rsp_vld, dp_rsp_state, dp_rsp_action,
           cp_req_rdy, cp_rsp_vld, cp_rsp_rdata, timeout_err
  );
endinterface

// File: rtl/stateful_tbl_arb.sv
// stateful_tbl_arb
//   16 x 24-bit state table shared between a datapath agent (lookup, then
//   commit/release under a per-entry lock) and a control-plane agent (full
//   entry read/write). One table access per cycle. The control plane is
//   protected from starvation by a grant counter; a held lock is dropped
//   after HOLD_TIMEOUT cycles.
// Parameters
//   STARVE_MAX   consecutive datapath grants allowed while the CP waits
//   HOLD_TIMEOUT maximum HOLD cycles before the lock is dropped
// Ports
//   clk     sole clock, rising edge
//   rst_n   asynchronous active-low reset
//   io_tbl  stateful_tbl_arb_if.slave (all handshake/data signals)
//   o_dp_grant_cnt, o_cp_grant_cnt, o_timeout_cnt
//           16-bit saturating statistics, present only when the macro
//           STATE_TBL_STATS_EN is defined
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no lock; datapath lookups and CP accesses arbitrated
// HOLD  | entry lock_idx locked by the datapath, waiting for dp_upd or
//       | timeout; CP accesses allowed except writes to lock_idx
module stateful_tbl_arb #(
  parameter int STARVE_MAX   = 4,
  parameter int HOLD_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  stateful_tbl_arb_if.slave  io_tbl
`ifdef STATE_TBL_STATS_EN
  ,
  output logic [15:0]        o_dp_grant_cnt,
  output logic [15:0]        o_cp_grant_cnt,
  output logic [15:0]        o_timeout_cnt
`endif
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int HW = (HOLD_TIMEOUT < 2) ? 1 : $clog2(HOLD_TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX_V = SW'(STARVE_MAX);
  localparam logic [HW-1:0] HOLD_LOAD_V  = HW'(HOLD_TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [23:0]     r_tbl [16];
  logic [3:0]      r_lock_idx;
  logic [SW-1:0]   r_starve_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_dp_rsp_vld;
  logic [23:0]     r_dp_rsp_data;
  logic            r_cp_rsp_vld;
  logic [23:0]     r_cp_rsp_data;
  logic            r_timeout_err;

  logic            w_cp_gnt;
  logic            w_dp_rdy;
  logic            w_dp_gnt;
  logic            w_upd_take;
  logic            w_hold_tc;
  logic            w_tbl_we;
  logic [3:0]      w_tbl_widx;
  logic [23:0]     w_tbl_wdata;

  // Updates arriving in the response cycle (first HOLD cycle) are ignored.
  assign w_upd_take = (r_state == ST_HOLD) && io_tbl.dp_upd_vld && !r_dp_rsp_vld;
  // Hold timer runs down from HOLD_TIMEOUT-1; zero marks the last HOLD cycle.
  assign w_hold_tc  = (r_state == ST_HOLD) && (r_hold_cnt == '0);
  assign w_dp_gnt   = w_dp_rdy && io_tbl.dp_req_vld;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_dp_gnt) w_state_nxt = ST_HOLD;
      ST_HOLD: if (w_upd_take || w_hold_tc) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cp_gnt = 1'b0;
    w_dp_rdy = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cp_gnt = io_tbl.cp_req_vld &&
                   (!io_tbl.dp_req_vld || (r_starve_cnt == STARVE_MAX_V));
        w_dp_rdy = !w_cp_gnt;
      end
      ST_HOLD: begin
        // A CP write to the locked entry stalls; an update owns the table port.
        w_cp_gnt = io_tbl.cp_req_vld && !io_tbl.dp_upd_vld &&
                   (!io_tbl.cp_req_wr || (io_tbl.cp_req_idx != r_lock_idx));
      end
      default: begin
        w_cp_gnt = 1'b0;
        w_dp_rdy = 1'b0;
      end
    endcase
  end

  // Ready outputs are forced low while reset is asserted; the registers are
  // already held in reset, so only the outputs need the gate.
  assign io_tbl.dp_req_rdy = w_dp_rdy && rst_n;
  assign io_tbl.cp_req_rdy = w_cp_gnt && rst_n;

  // ---------------------------------------------------------- table port
  always_comb begin
    w_tbl_we    = 1'b0;
    w_tbl_widx  = io_tbl.cp_req_idx;
    w_tbl_wdata = io_tbl.cp_req_wdata;
    if (w_cp_gnt && io_tbl.cp_req_wr) begin
      w_tbl_we = 1'b1;
    end else if (w_upd_take && io_tbl.dp_upd_wr) begin
      w_tbl_we    = 1'b1;
      w_tbl_widx  = r_lock_idx;
      w_tbl_wdata = {r_tbl[r_lock_idx][23:8], io_tbl.dp_upd_state};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_tbl[i] <= '0;
      end
    end else if (w_tbl_we) begin
      r_tbl[w_tbl_widx] <= w_tbl_wdata;
    end
  end

  // ------------------------------------------------ lock, timers, responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_idx    <= '0;
      r_hold_cnt    <= '0;
      r_starve_cnt  <= '0;
      r_dp_rsp_vld  <= 1'b0;
      r_dp_rsp_data <= '0;
      r_cp_rsp_vld  <= 1'b0;
      r_cp_rsp_data <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_dp_gnt) begin
        r_lock_idx <= io_tbl.dp_req_idx;
        r_hold_cnt <= HOLD_LOAD_V;
      end else if ((r_state == ST_HOLD) && !w_upd_take && !w_hold_tc) begin
        r_hold_cnt <= r_hold_cnt - HW'(1);
      end

      if (w_cp_gnt) begin
        r_starve_cnt <= '0;
      end else if (w_dp_gnt && io_tbl.cp_req_vld && (r_starve_cnt != STARVE_MAX_V)) begin
        r_starve_cnt <= r_starve_cnt + SW'(1);
      end

      // Reads sample the table before this cycle's write lands.
      r_dp_rsp_vld <= w_dp_gnt;
      if (w_dp_gnt) begin
        r_dp_rsp_data <= r_tbl[io_tbl.dp_req_idx];
      end

      r_cp_rsp_vld <= w_cp_gnt && !io_tbl.cp_req_wr;
      if (w_cp_gnt && !io_tbl.cp_req_wr) begin
        r_cp_rsp_data <= r_tbl[io_tbl.cp_req_idx];
      end

      r_timeout_err <= w_hold_tc && !w_upd_take;
    end
  end

  assign io_tbl.dp_rsp_vld    = r_dp_rsp_vld;
  assign io_tbl.dp_rsp_state  = r_dp_rsp_data[7:0];
  assign io_tbl.dp_rsp_action = r_dp_rsp_data[23:8];
  assign io_tbl.cp_rsp_vld    = r_cp_rsp_vld;
  assign io_tbl.cp_rsp_rdata  = r_cp_rsp_data;
  assign io_tbl.timeout_err   = r_timeout_err;

`ifdef STATE_TBL_STATS_EN
  // ------------------------------------------------- saturating statistics
  logic [15:0] r_dp_grant_cnt;
  logic [15:0] r_cp_grant_cnt;
  logic [15:0] r_timeout_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_grant_cnt <= '0;
      r_cp_grant_cnt <= '0;
      r_timeout_cnt  <= '0;
    end else begin
      if (w_dp_gnt && (r_dp_grant_cnt != 16'hFFFF)) begin
        r_dp_grant_cnt <= r_dp_grant_cnt + 16'd1;
      end
      if (w_cp_gnt && (r_cp_grant_cnt != 16'hFFFF)) begin
        r_cp_grant_cnt <= r_cp_grant_cnt + 16'd1;
      end
      if (w_hold_tc && !w_upd_take && (r_timeout_cnt != 16'hFFFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 16'd1;
      end
    end
  end

  assign o_dp_grant_cnt = r_dp_grant_cnt;
  assign o_cp_grant_cnt = r_cp_grant_cnt;
  assign o_timeout_cnt  = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_stateful_tbl_arb.sv
module tb_stateful_tbl_arb;
  localparam int STARVE_MAX   = 4;
  localparam int HOLD_TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stateful_tbl_arb_if bus ();

`ifdef STATE_TBL_STATS_EN
  logic [15:0] st_dp_cnt, st_cp_cnt, st_to_cnt;
`endif

  stateful_tbl_arb #(
    .STARVE_MAX  (STARVE_MAX),
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_tbl(bus)
`ifdef STATE_TBL_STATS_EN
    ,
    .o_dp_grant_cnt(st_dp_cnt),
    .o_cp_grant_cnt(st_cp_cnt),
    .o_timeout_cnt (st_to_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // ------------------------------------------------------------ model
  // Table contents, lock ownership and the age of the lock (HOLD cycles
  // already spent), advanced once per cycle from the inputs seen.
  logic [23:0] m_tbl [16];
  bit          m_hold;
  logic [3:0]  m_lock;
  int          m_age;
  int          m_starve;
  bit          m_cp_ok, m_dp_ok, m_upd, m_tmo;
  bit          e_dp_vld, e_cp_vld, e_to;
  logic [23:0] e_dp_data, e_cp_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_hold = 0; m_lock = '0; m_age = 0; m_starve = 0;
      for (int i = 0; i < 16; i++) m_tbl[i] = '0;
      e_dp_vld = 0; e_cp_vld = 0; e_to = 0; e_dp_data = '0; e_cp_data = '0;
      check("rst dp_req_rdy",    32'(bus.dp_req_rdy),    32'd0);
      check("rst cp_req_rdy",    32'(bus.cp_req_rdy),    32'd0);
      check("rst dp_rsp_vld",    32'(bus.dp_rsp_vld),    32'd0);
      check("rst dp_rsp_state",  32'(bus.dp_rsp_state),  32'd0);
      check("rst dp_rsp_action", 32'(bus.dp_rsp_action), 32'd0);
      check("rst cp_rsp_vld",    32'(bus.cp_rsp_vld),    32'd0);
      check("rst cp_rsp_rdata",  32'(bus.cp_rsp_rdata),  32'd0);
      check("rst timeout_err",   32'(bus.timeout_err),   32'd0);
    end else begin
      if (!m_hold)
        m_cp_ok = bus.cp_req_vld && (!bus.dp_req_vld || (m_starve == STARVE_MAX));
      else
        m_cp_ok = bus.cp_req_vld && !bus.dp_upd_vld &&
                  (!bus.cp_req_wr || (bus.cp_req_idx != m_lock));
      m_dp_ok = !m_hold && !m_cp_ok && bus.dp_req_vld;

      check("dp_req_rdy",  32'(bus.dp_req_rdy),  32'(!m_hold && !m_cp_ok));
      check("cp_req_rdy",  32'(bus.cp_req_rdy),  32'(m_cp_ok));
      check("dp_rsp_vld",  32'(bus.dp_rsp_vld),  32'(e_dp_vld));
      check("cp_rsp_vld",  32'(bus.cp_rsp_vld),  32'(e_cp_vld));
      check("timeout_err", 32'(bus.timeout_err), 32'(e_to));
      if (e_dp_vld) begin
        check("dp_rsp_state",  32'(bus.dp_rsp_state),  32'(e_dp_data[7:0]));
        check("dp_rsp_action", 32'(bus.dp_rsp_action), 32'(e_dp_data[23:8]));
      end
      if (e_cp_vld) check("cp_rsp_rdata", 32'(bus.cp_rsp_rdata), 32'(e_cp_data));

      m_upd = m_hold && bus.dp_upd_vld && (m_age != 0);
      m_tmo = m_hold && !m_upd && (m_age + 1 == HOLD_TIMEOUT);
      e_dp_vld = m_dp_ok;
      if (m_dp_ok) e_dp_data = m_tbl[bus.dp_req_idx];
      e_cp_vld = m_cp_ok && !bus.cp_req_wr;
      if (e_cp_vld) e_cp_data = m_tbl[bus.cp_req_idx];
      e_to = m_tmo;
      if (m_cp_ok && bus.cp_req_wr) m_tbl[bus.cp_req_idx] = bus.cp_req_wdata;
      if (m_upd && bus.dp_upd_wr) m_tbl[m_lock][7:0] = bus.dp_upd_state;
      if (m_cp_ok) m_starve = 0;
      else if (m_dp_ok && bus.cp_req_vld && (m_starve < STARVE_MAX)) m_starve++;
      if (m_dp_ok) begin
        m_hold = 1; m_lock = bus.dp_req_idx; m_age = 0;
      end else if (m_hold) begin
        if (m_upd || m_tmo) m_hold = 0;
        else m_age++;
      end
    end
  end

  // -------------------------------------------------------- stimulus
  logic s_dp_rdy, s_cp_rdy;

  task automatic drive(input logic dv, input logic [3:0] di,
                       input logic uv, input logic uw, input logic [7:0] us,
                       input logic cv, input logic cw, input logic [3:0] ci,
                       input logic [23:0] cd);
    bus.dp_req_vld = dv; bus.dp_req_idx = di;
    bus.dp_upd_vld = uv; bus.dp_upd_wr = uw; bus.dp_upd_state = us;
    bus.cp_req_vld = cv; bus.cp_req_wr = cw; bus.cp_req_idx = ci; bus.cp_req_wdata = cd;
    @(negedge clk);
    s_dp_rdy = bus.dp_req_rdy;
    s_cp_rdy = bus.cp_req_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();                                   drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic dp_look(input logic [3:0] i);             drive(1, i, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic dp_upd(input logic w, input logic [7:0] s); drive(0, 0, 1, w, s, 0, 0, 0, 0); endtask
  task automatic cp_wr(input logic [3:0] i, input logic [23:0] d); drive(0, 0, 0, 0, 0, 1, 1, i, d); endtask
  task automatic cp_rd(input logic [3:0] i);               drive(0, 0, 0, 0, 0, 1, 0, i, 0); endtask

  int dp_run, cp_seen, k;

  initial begin
    // Requests held during reset must not be acknowledged.
    bus.dp_req_vld = 1; bus.dp_req_idx = 0;
    bus.dp_upd_vld = 0; bus.dp_upd_wr = 0; bus.dp_upd_state = 0;
    bus.cp_req_vld = 1; bus.cp_req_wr = 0; bus.cp_req_idx = 0; bus.cp_req_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    dp_look(0);
    check("first grant after reset", 32'(bus.dp_rsp_vld), 32'd1);
    idle();
    dp_upd(0, 0);

    // CP write then DP lookup of the same entry.
    cp_wr(3, 24'h00AB12);
    check("cp write granted", 32'(s_cp_rdy), 32'd1);
    dp_look(3);
    check("lookup idx3 vld",    32'(bus.dp_rsp_vld),    32'd1);
    check("lookup idx3 state",  32'(bus.dp_rsp_state),  32'h12);
    check("lookup idx3 action", 32'(bus.dp_rsp_action), 32'h00AB);
    dp_upd(1, 8'hEE);          // response cycle: ignored
    check("dp_rsp single pulse", 32'(bus.dp_rsp_vld), 32'd0);
    dp_upd(1, 8'h55);
    drive(0, 0, 1, 1, 8'h99, 0, 0, 0, 0);  // update while IDLE: ignored
    check("back in idle", 32'(s_dp_rdy), 32'd1);
    cp_rd(3);
    check("commit read vld",  32'(bus.cp_rsp_vld),   32'd1);
    check("commit read data", 32'(bus.cp_rsp_rdata), 32'h00AB55);

    // CP writes against a lock on idx5.
    dp_look(5);
    cp_wr(5, 24'h555555);
    check("write locked stall 1", 32'(s_cp_rdy), 32'd0);
    cp_wr(5, 24'h555555);
    check("write locked stall 2", 32'(s_cp_rdy), 32'd0);
    cp_wr(6, 24'h666666);
    check("write other granted", 32'(s_cp_rdy), 32'd1);
    drive(0, 0, 1, 0, 0, 1, 1, 5, 24'h555555);
    check("write blocked by upd", 32'(s_cp_rdy), 32'd0);
    cp_wr(5, 24'h555555);
    check("write after release", 32'(s_cp_rdy), 32'd1);
    cp_rd(5);
    check("idx5 data", 32'(bus.cp_rsp_rdata), 32'h555555);
    cp_rd(6);
    check("idx6 data", 32'(bus.cp_rsp_rdata), 32'h666666);

    // Both agents requesting continuously.
    dp_run = 0; cp_seen = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1, 7, 1, 0, 0, 1, 1, 7, 24'h0000C3);
      if (s_dp_rdy) dp_run++;
      if (s_cp_rdy) begin
        check("dp grants between cp grants", 32'(dp_run), 32'd4);
        cp_seen++;
        dp_run = 0;
      end
    end
    check("cp grants in 40 cycles", 32'(cp_seen), 32'd3);
    idle();
    dp_upd(0, 0);

    // Lock timeout.
    cp_wr(9, 24'h123456);
    dp_look(9);
    k = 0;
    while (bus.timeout_err !== 1'b1 && k < 100) begin
      idle();
      k++;
    end
    check("timeout latency", 32'(k), 32'd64);
    dp_upd(1, 8'hFF);          // late update: discarded
    check("timeout single pulse", 32'(bus.timeout_err), 32'd0);
    cp_rd(9);
    check("entry after timeout", 32'(bus.cp_rsp_rdata), 32'h123456);

    // Reset in the middle of HOLD, while the response is pending.
    dp_look(3);
    check("pre-reset rsp vld",   32'(bus.dp_rsp_vld),   32'd1);
    check("pre-reset rsp state", 32'(bus.dp_rsp_state), 32'h55);
    bus.dp_req_vld = 1; bus.dp_req_idx = 3;
    bus.cp_req_vld = 1; bus.cp_req_wr = 0; bus.cp_req_idx = 7;
    #2;
    rst_n = 0;
    #1;
    check("async rst dp_rsp_vld",    32'(bus.dp_rsp_vld),    32'd0);
    check("async rst dp_rsp_action", 32'(bus.dp_rsp_action), 32'd0);
    check("async rst dp_req_rdy",    32'(bus.dp_req_rdy),    32'd0);
    check("async rst cp_req_rdy",    32'(bus.cp_req_rdy),    32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.cp_req_vld = 0;
    rst_n = 1;
    dp_look(3);
    check("post-reset lookup vld",    32'(bus.dp_rsp_vld),    32'd1);
    check("post-reset lookup state",  32'(bus.dp_rsp_state),  32'd0);
    check("post-reset lookup action", 32'(bus.dp_rsp_action), 32'd0);
    idle();
    dp_upd(0, 0);
    cp_rd(5);
    check("post-reset idx5", 32'(bus.cp_rsp_rdata), 32'd0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
